ceespu_writeback: RTL
=====================

Name: ceespu_writeback

Overview:
- Write-side companion to the CPU register file: collects results from the ALU and from the load-return path, buffers them, and issues them to the register file's single write port (we / selD / dataD), one write per cycle.
- Also provides read-side forwarding. Decode sees pending, not-yet-committed values for its two source selects, so register reads stay coherent while writes are queued.

Parameters:
- DEPTH, 4, write-buffer entries (power of two, >= 2)
- DATA_W, 32, result data width
- SEL_W, 5, register select width

Ports:
- I_clk  in  1  clock
- I_rst  in  1  asynchronous active-low reset
- I_alu_valid  in  1  ALU result present this cycle
- I_alu_sel  in  SEL_W  ALU destination register
- I_alu_data  in  DATA_W  ALU result
- I_mem_valid  in  1  load data present this cycle
- I_mem_sel  in  SEL_W  load destination register
- I_mem_data  in  DATA_W  load data
- O_stall  out  1  fewer than 2 free buffer slots; inputs ignored while high
- O_we  out  1  register-file write enable (registered)
- O_selD  out  SEL_W  register-file write select (registered)
- O_dataD  out  DATA_W  register-file write data (registered)
- I_selA  in  SEL_W  decode source select A
- I_selB  in  SEL_W  decode source select B
- I_rfA  in  DATA_W  register-file read data for I_selA
- I_rfB  in  DATA_W  register-file read data for I_selB
- O_dataA  out  DATA_W  forwarded operand A (combinational)
- O_dataB  out  DATA_W  forwarded operand B (combinational)
- O_count  out  log2(DEPTH)+1  current buffer occupancy

Behaviour:
- Reset (I_rst=0, asynchronous): count, read and write pointers = 0; O_we=0, O_selD=0, O_dataD=0; O_stall=0. Buffer contents are not reset; valid-ness comes from the count only.
- The buffer is a circular FIFO. Each entry holds {sel, data}. Pointers wrap modulo DEPTH.
- O_stall = (DEPTH - count) < 2. It is computed from the registered count only; the same-cycle dequeue is not credited.
- Enqueue happens at a clock edge when O_stall=0:
  - Only mem valid: push mem.
  - Only alu valid: push alu.
  - Both valid: push mem first (older), then alu. Two pushes in one cycle.
  - While O_stall=1, both inputs are ignored. Producers must hold them; nothing is enqueued.
- Dequeue happens at every edge where count>0 before the edge:
  - Head entry is loaded into O_selD/O_dataD, O_we=1, read pointer advances.
  - If count=0, O_we=0 and O_selD/O_dataD hold their last values.
- Count update: count_next = count + pushes - pop. Simultaneous push and pop in the same cycle is legal.
- Latency: a result enqueued at edge N appears on O_we/O_selD/O_dataD after edge N+1 (buffer was empty) and is written by the register file at edge N+2. Write order equals enqueue order.
- There is no special handling for register 0; every select is written as-is.
- Forwarding (combinational, per port; port B is identical):
  - O_dataA = newest valid buffer entry with sel==I_selA.
  - Otherwise, O_dataD if O_we=1 and O_selD==I_selA.
  - Otherwise, I_rfA.
  - "Newest" means closest to the write pointer.
  - Same-cycle inputs (I_alu_*/I_mem_*) are not forwarded.
- Reset asserted mid-operation: pending entries are discarded and O_we drops immediately (asynchronously). No further writes are issued.

Test Plan:
- Hold I_rst=0 three cycles with I_alu_valid=1 -> O_we=0, O_count=0, O_stall=0. Release reset -> first push accepted at the next edge.
- ALU r5=0x1234 at edge N, buffer empty, I_rfA=0, I_selA=5:
  - After edge N: O_dataA=0x1234, O_count=1.
  - After edge N+1: O_we=1, O_selD=5, O_dataD=0x1234, O_count=0.
  - After edge N+2: O_we=0.
- Same cycle, mem r3=0xA and alu r3=0xB -> consecutive writes r3=0xA then r3=0xB. O_dataB with I_selB=3 reads 0xB until both retire.
- Dual pushes on 3 consecutive cycles, DEPTH=4:
  - O_count after the edges goes 2, 3; O_stall=1 at count 3.
  - The third pair is ignored until count falls to 2.
  - All accepted writes appear in order; no ignored value is ever written.
- Forward priority: r7=1 in the output register and r7=2 in the buffer -> O_dataA=2. After the buffer entry retires -> O_dataA=2 from the output register, then from I_rfA.
- Reset with 3 entries pending -> O_we=0 within the reset cycle. O_count=0. No write is issued after reset is released.

Source files
------------

// File: rtl/ceespu_writeback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ceespu_writeback: buffers ALU/load results for the single register-file  |
// | write port and forwards pending values to the decode read ports.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ceespu_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic                     I_alu_valid,
  input  logic [SEL_W-1:0]         I_alu_sel,
  input  logic [DATA_W-1:0]        I_alu_data,
  input  logic                     I_mem_valid,
  input  logic [SEL_W-1:0]         I_mem_sel,
  input  logic [DATA_W-1:0]        I_mem_data,
  output logic                     O_stall,
  output logic                     O_we,
  output logic [SEL_W-1:0]         O_selD,
  output logic [DATA_W-1:0]        O_dataD,
  input  logic [SEL_W-1:0]         I_selA,
  input  logic [SEL_W-1:0]         I_selB,
  input  logic [DATA_W-1:0]        I_rfA,
  input  logic [DATA_W-1:0]        I_rfB,
  output logic [DATA_W-1:0]        O_dataA,
  output logic [DATA_W-1:0]        O_dataB,
  output logic [$clog2(DEPTH):0]   O_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  // Stall once fewer than two slots remain, so a dual push can never overflow.
  localparam logic [CNT_W-1:0] C_STALL_AT = CNT_W'(DEPTH - 1);

  logic [SEL_W-1:0]  rSelMem  [DEPTH];
  logic [DATA_W-1:0] rDataMem [DEPTH];
  logic [PTR_W-1:0]  rWrPtr;
  logic [PTR_W-1:0]  rRdPtr;
  logic [CNT_W-1:0]  rCount;

  logic              wStall;
  logic              wPushMem;
  logic              wPushAlu;
  logic              wPop;
  logic [PTR_W-1:0]  wAluPtr;
  logic [CNT_W-1:0]  wCountNext;
  logic [PTR_W-1:0]  wIdx;
  logic [DATA_W-1:0] wDataA;
  logic [DATA_W-1:0] wDataB;

  assign wStall     = rCount >= C_STALL_AT;
  assign wPushMem   = I_mem_valid && !wStall;
  assign wPushAlu   = I_alu_valid && !wStall;
  assign wPop       = rCount != '0;
  // Load data is older than the ALU result, so it takes the first slot.
  assign wAluPtr    = wPushMem ? rWrPtr + PTR_W'(1) : rWrPtr;
  assign wCountNext = rCount + CNT_W'(wPushMem) + CNT_W'(wPushAlu) - CNT_W'(wPop);

  always_ff @(posedge I_clk) begin
    if (wPushMem) begin
      rSelMem[rWrPtr]  <= I_mem_sel;
      rDataMem[rWrPtr] <= I_mem_data;
    end
    if (wPushAlu) begin
      rSelMem[wAluPtr]  <= I_alu_sel;
      rDataMem[wAluPtr] <= I_alu_data;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      rWrPtr  <= '0;
      rRdPtr  <= '0;
      rCount  <= '0;
      O_we    <= 1'b0;
      O_selD  <= '0;
      O_dataD <= '0;
    end else begin
      rWrPtr <= rWrPtr + PTR_W'(wPushMem) + PTR_W'(wPushAlu);
      rCount <= wCountNext;
      O_we   <= wPop;
      if (wPop) begin
        O_selD  <= rSelMem[rRdPtr];
        O_dataD <= rDataMem[rRdPtr];
        rRdPtr  <= rRdPtr + PTR_W'(1);
      end
    end
  end

  // Walk oldest to newest so the newest matching entry wins.
  always_comb begin
    wIdx   = '0;
    wDataA = (O_we && (O_selD == I_selA)) ? O_dataD : I_rfA;
    wDataB = (O_we && (O_selD == I_selB)) ? O_dataD : I_rfB;
    for (int i = 0; i < DEPTH; i++) begin
      wIdx = rRdPtr + PTR_W'(i);
      if (CNT_W'(i) < rCount) begin
        if (rSelMem[wIdx] == I_selA) wDataA = rDataMem[wIdx];
        if (rSelMem[wIdx] == I_selB) wDataB = rDataMem[wIdx];
      end
    end
  end

  assign O_dataA = wDataA;
  assign O_dataB = wDataB;
  assign O_stall = wStall;
  assign O_count = rCount;

endmodule
`default_nettype wire
